// File: rtl/ahead_sub_serial.sv
// ahead_sub_serial: multi-cycle borrow-lookahead subtractor, D = A - B - bin.
// One 4-bit nibble per clock through a single lookahead slice, LSB first.
// Optional signed-overflow output enabled by defining AHEAD_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | processing nibble k, borrow chained through br_r
// DONE  | result held, out_valid high until out_ready
module ahead_sub_serial #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   D,
  output logic                   bout
`ifdef AHEAD_SUB_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k;
  logic [W-1:0]  a_r, b_r;
  logic          br_r;
  logic          last;
  logic [3:0]    a, b, g, p, d;
  logic          c0, c1, c2, c3;

  assign last = (k == KW'(NIBBLES - 1));
  assign a    = a_r[4*k +: 4];
  assign b    = b_r[4*k +: 4];

  // Borrow-lookahead slice: every borrow is a flat sum of products of g/p/br.
  always_comb begin
    g  = ~a & b;
    p  = ~a | b;
    c0 = g[0] | (p[0] & br_r);
    c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_r);
    c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br_r);
    c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & br_r);
    d  = a ^ b ^ {c2, c1, c0, br_r};
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered handshake decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Operand capture and per-nibble result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      br_r <= 1'b0;
      k    <= '0;
      D    <= '0;
      bout <= 1'b0;
`ifdef AHEAD_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r  <= A;
          b_r  <= B;
          br_r <= bin;
          k    <= '0;
          D    <= '0;
        end
        RUN: begin
          D[4*k +: 4] <= d;
          br_r        <= c3;
          k           <= k + 1'b1;
          if (last) begin
            bout <= c3;
`ifdef AHEAD_SUB_OVF_EN
            ovf  <= (a_r[W-1] ^ b_r[W-1]) & (a_r[W-1] ^ d[3]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahead_sub_serial.sv
// tb_ahead_sub_serial: scoreboard bench for ahead_sub_serial (NIBBLES=4).
module tb_ahead_sub_serial;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         bout;
`ifdef AHEAD_SUB_OVF_EN
  logic         ovf;
`endif

  ahead_sub_serial #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .bout(bout)
`ifdef AHEAD_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W+1:0] sb[$];   // {ovf, bout, D}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] r;
    logic       ov;
    r  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ r[W-1]);
    return {ov, r[W], r[W-1:0]};
  endfunction

  // Accept one operand, check latency, stall, then consume and score.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input int stall);
    int lat;
    logic [W+1:0] e;
    logic [W-1:0] d_hold;
    logic         b_hold;
    chk("in_ready_before", in_ready, 1'b1);
    A = a; B = b; bin = bi; in_valid = 1'b1;
    sb.push_back(model(a, b, bi));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; A = '1; B = '0; bin = 1'b1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("latency", lat, N + 1);
    d_hold = D; b_hold = bout;
    for (int i = 0; i < stall; i++) begin
      if (i == stall / 2) in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_D", D, d_hold);
      chk("stall_bout", bout, b_hold);
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("D", D, e[W-1:0]);
      chk("bout", bout, e[W]);
`ifdef AHEAD_SUB_OVF_EN
      chk("ovf", ovf, e[W+1]);
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_valid", out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_D", D, '0);
    chk("rst_bout", bout, 1'b0);
`ifdef AHEAD_SUB_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif

    run_op(16'h1234, 16'h0234, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    run_op(16'h0005, 16'h0005, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op(16'hABCD, 16'h1234, 1'b0, 10);

    // Reset while RUN is at nibble 2 discards the partial result.
    A = 16'h9999; B = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_D", D, '0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 300; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
